// File: rtl/advtim_cnt_pwm.sv
// -----------------------------------------------------------------------------
// advtim_cnt_pwm
// Output-compare / PWM counter for the advanced timer PE core.
//
// A prescaler (psc) and an auto-reload counter (arr) form the time base.
// The count is compared with a shadowed compare value to build the oc1ref
// waveform. A dead-time stage derives the complementary pair oc1p/oc1n from
// oc1ref. A repetition counter gives N-period bursts, or continuous output
// when r_rcr is 0.
//
// Ports
//   pe_pwm_clk               block clock
//   pe_pwm_rst               synchronous reset, active high
//   pe_pwm_tim_enable        level enable, sampled in IDLE to start a run
//   pe_pwm_logic_clr         one-cycle abort back to IDLE (highest priority)
//   r_psc / r_arr            prescaler ratio / period in psc units (0 acts as 1)
//   r_ccr1                   compare value
//   r_rcr                    number of periods per burst, 0 = continuous
//   r_oc1m                   0 = PWM1 (active while cnt<ccr), 1 = PWM2
//   r_dtg                    dead time in clocks
//   oc1ref                   reference waveform
//   oc1p / oc1n              main / complementary output with dead time
//   pe_pwm_tim_end           pulse: burst complete
//   pe_pwm_hw_update         pulse: shadow registers loaded
//   int_status_pwm_end       copy of pe_pwm_tim_end
//   int_status_pwm_reloaded  pulse at every period end that reloads shadows
//
// All outputs are registered. Event pulses appear in the cycle right after
// the clock edge on which the event took effect, so hw_update is high in the
// first cycle of every period and tim_end in the first IDLE cycle.
// -----------------------------------------------------------------------------
module advtim_cnt_pwm #(
  parameter int CNT_W = 16,
  parameter int DTG_W = 8
) (
  input  logic             pe_pwm_clk,
  input  logic             pe_pwm_rst,
  input  logic             pe_pwm_tim_enable,
  input  logic             pe_pwm_logic_clr,
  input  logic [CNT_W-1:0] r_psc,
  input  logic [CNT_W-1:0] r_arr,
  input  logic [CNT_W-1:0] r_ccr1,
  input  logic [CNT_W-1:0] r_rcr,
  input  logic             r_oc1m,
  input  logic [DTG_W-1:0] r_dtg,
  output logic             oc1ref,
  output logic             oc1p,
  output logic             oc1n,
  output logic             pe_pwm_tim_end,
  output logic             pe_pwm_hw_update,
  output logic             int_status_pwm_end,
  output logic             int_status_pwm_reloaded
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DTG_W-1:0] DTG_ONE = DTG_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A programmed ratio of 0 behaves like 1 so the time base never stalls.
  function automatic logic [CNT_W-1:0] nonzero(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  // Dead-time counter counts down to 0 and holds there.
  function automatic logic [DTG_W-1:0] sat_dec(input logic [DTG_W-1:0] v);
    return (v == '0) ? '0 : (v - DTG_ONE);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] psc_cnt;
  logic [CNT_W-1:0] arr_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] psc_last;
  logic [CNT_W-1:0] arr_last;
  logic [CNT_W-1:0] ccr_last;
  logic [DTG_W-1:0] dt_cnt;

  logic             start;
  logic             abort;
  logic             psc_wrap;
  logic             arr_wrap;
  logic             cnt_end;
  logic             final_end;
  logic             reload;
  logic             run_n;
  logic [CNT_W-1:0] arr_n;
  logic [CNT_W-1:0] ccr_n;
  logic             ref_n;
  logic             ref_edge;
  logic [DTG_W-1:0] dt_n;

  // ---- stage p0: decode the current cycle and form next-cycle values ----
  always_comb begin
    start     = (state == IDLE) && pe_pwm_tim_enable && !pe_pwm_logic_clr;
    abort     = (state == RUN) && (pe_pwm_logic_clr || !pe_pwm_tim_enable);
    psc_wrap  = (psc_cnt == (nonzero(psc_last) - CNT_ONE));
    arr_wrap  = (arr_cnt == (nonzero(arr_last) - CNT_ONE));
    cnt_end   = (state == RUN) && psc_wrap && arr_wrap;
    final_end = cnt_end && (r_rcr != '0) && (period_cnt == (r_rcr - CNT_ONE));
    // The final period end skips the shadow reload; an abort overrides both.
    reload    = cnt_end && !final_end && !abort;
    run_n     = start || ((state == RUN) && !abort && !final_end);

    // Next-cycle arr count and compare value, so the registered oc1ref lines
    // up with the counters it is derived from.
    ccr_n = (start || reload) ? r_ccr1 : ccr_last;
    arr_n = arr_cnt;
    if (!run_n || start || reload) begin
      arr_n = '0;
    end else if (psc_wrap) begin
      arr_n = arr_cnt + CNT_ONE;
    end

    ref_n = run_n && ((arr_n < ccr_n) ^ r_oc1m);

    // Entering RUN starts a fresh phase even when oc1ref stays low, so the
    // first low phase also honours the dead time on oc1n.
    ref_edge = (ref_n != oc1ref) || (state == IDLE);
    dt_n     = ref_edge ? r_dtg : sat_dec(dt_cnt);
  end

  // ---- stage p1: registered state, counters, shadows and outputs ----
  always_ff @(posedge pe_pwm_clk) begin
    if (pe_pwm_rst) begin
      state                   <= IDLE;
      psc_cnt                 <= '0;
      arr_cnt                 <= '0;
      period_cnt              <= '0;
      psc_last                <= '0;
      arr_last                <= '0;
      ccr_last                <= '0;
      dt_cnt                  <= '0;
      oc1ref                  <= 1'b0;
      oc1p                    <= 1'b0;
      oc1n                    <= 1'b0;
      pe_pwm_tim_end          <= 1'b0;
      pe_pwm_hw_update        <= 1'b0;
      int_status_pwm_reloaded <= 1'b0;
    end else begin
      pe_pwm_tim_end          <= final_end && !abort;
      pe_pwm_hw_update        <= start || reload;
      int_status_pwm_reloaded <= reload;

      oc1ref <= ref_n;
      oc1p   <= run_n && ref_n && (dt_n == '0);
      oc1n   <= run_n && !ref_n && (dt_n == '0);
      dt_cnt <= run_n ? dt_n : '0;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            psc_cnt    <= '0;
            arr_cnt    <= '0;
            period_cnt <= '0;
            psc_last   <= r_psc;
            arr_last   <= r_arr;
            ccr_last   <= r_ccr1;
          end
        end
        RUN: begin
          if (abort || final_end) begin
            state      <= IDLE;
            psc_cnt    <= '0;
            arr_cnt    <= '0;
            period_cnt <= '0;
          end else if (psc_wrap) begin
            psc_cnt <= '0;
            if (arr_wrap) begin
              arr_cnt  <= '0;
              psc_last <= r_psc;
              arr_last <= r_arr;
              ccr_last <= r_ccr1;
              if (r_rcr != '0) begin
                period_cnt <= period_cnt + CNT_ONE;
              end
            end else begin
              arr_cnt <= arr_cnt + CNT_ONE;
            end
          end else begin
            psc_cnt <= psc_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign int_status_pwm_end = pe_pwm_tim_end;

endmodule
